// File: rtl/ffip_pkg.sv
// ffip_pkg: shared types and helpers for the fast-inner-product accumulator.
//   ffip_state_t : group FSM states
//   term_size()  : width of the p0 - p1 - p2 intermediate for a given product width
//   TERM_SIZE    : term width for the default 18-bit product lanes
//   sat_add()    : signed saturating add, present only when FFIP_ACC_SAT_EN is defined
package ffip_pkg;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} ffip_state_t;

  localparam int unsigned PROD_SIZE_DEF = 18;

  // Two extra bits cover the worst case p0 - p1 - p2 of three full-range lanes.
  function automatic int unsigned term_size(input int unsigned prod_size);
    return prod_size + 2;
  endfunction

  localparam int unsigned TERM_SIZE = term_size(PROD_SIZE_DEF);

`ifdef FFIP_ACC_SAT_EN
  // Operands are sign-extended w-bit values (w <= 62), so the 64-bit sum is exact
  // and only needs clamping back into the w-bit signed range.
  function automatic longint sat_add(input longint a, input longint b,
                                     input int unsigned w, output logic ovf);
    longint sum;
    longint hi;
    longint lo;
    sum = a + b;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    ovf = 1'b0;
    if (sum > hi) begin
      sat_add = hi;
      ovf     = 1'b1;
    end else if (sum < lo) begin
      sat_add = lo;
      ovf     = 1'b1;
    end else begin
      sat_add = sum;
    end
  endfunction
`endif

endpackage

// File: rtl/ffip_term.sv
// ffip_term: combinational fast-inner-product term p0 - p1 - p2, which equals
// a0*b0 + a1*b1 given the upstream pre-add/multiply products.
//   prod_i : three signed product lanes ([0] cross product, [1]/[2] corrections)
//   term_o : signed term, sign-extended to ACC_SIZE
module ffip_term #(
  parameter int unsigned PROD_SIZE = 18,
  parameter int unsigned ACC_SIZE  = 32
) (
  input  logic signed [PROD_SIZE-1:0] prod_i [0:2],
  output logic signed [ACC_SIZE-1:0]  term_o
);
  import ffip_pkg::*;

  localparam int unsigned TermSize = term_size(PROD_SIZE);

  logic signed [TermSize-1:0] p0, p1, p2, t;

  always_comb begin
    p0     = TermSize'(prod_i[0]);
    p1     = TermSize'(prod_i[1]);
    p2     = TermSize'(prod_i[2]);
    t      = p0 - p1 - p2;
    term_o = ACC_SIZE'(t);
  end

endmodule

// File: rtl/ffip_acc.sv
// ffip_acc: accumulates fast-inner-product terms over a group of len_i+1 beats
// and presents the dot-product result on a valid/ready output register.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   clear_i           : synchronous abort; drops the group, keeps out_data_o
//   len_i             : beats per group minus one, sampled on the first beat
//   in_valid_i/ready_o: product beat handshake
//   prod_i            : three signed product lanes
//   out_valid_o/ready_i, out_data_o : result handshake and signed result
//   busy_o            : group in progress
//   ovf_o             : sticky per-group saturation flag (FFIP_ACC_SAT_EN only)
// Define FFIP_ACC_SAT_EN for saturating accumulation; default is wrap-around.
module ffip_acc #(
  parameter int unsigned PROD_SIZE = 18,
  parameter int unsigned ACC_SIZE  = 32,
  parameter int unsigned LEN_SIZE  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic        [LEN_SIZE-1:0]  len_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic signed [PROD_SIZE-1:0] prod_i [0:2],
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic signed [ACC_SIZE-1:0]  out_data_o,
  output logic                        busy_o
`ifdef FFIP_ACC_SAT_EN
  ,
  output logic                        ovf_o
`endif
);
  import ffip_pkg::*;

  ffip_state_t               state_q, state_d;
  logic signed [ACC_SIZE-1:0] acc_q, acc_d;
  logic [LEN_SIZE-1:0]       cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACC_SIZE-1:0] out_data_q, out_data_d;

  logic signed [ACC_SIZE-1:0] term;
  logic signed [ACC_SIZE-1:0] acc_base;
  logic signed [ACC_SIZE-1:0] sum;
  logic                      beat;

  ffip_term #(
    .PROD_SIZE(PROD_SIZE),
    .ACC_SIZE (ACC_SIZE)
  ) u_term (
    .prod_i(prod_i),
    .term_o(term)
  );

  assign beat     = in_valid_i && in_ready_o;
  // The first beat of a group starts from zero rather than the stale accumulator.
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;

`ifdef FFIP_ACC_SAT_EN
  logic   ovf_q, ovf_d;
  logic   sat_ovf;
  longint sat_sum;

  always_comb begin
    sat_ovf = 1'b0;
    sat_sum = sat_add(longint'(acc_base), longint'(term), ACC_SIZE, sat_ovf);
    sum     = ACC_SIZE'(sat_sum);
  end

  assign ovf_o = ovf_q;
`else
  assign sum = acc_base + term;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef FFIP_ACC_SAT_EN
    ovf_d       = ovf_q;
`endif
    if (clear_i) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
`ifdef FFIP_ACC_SAT_EN
      ovf_d       = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (beat) begin
            acc_d = sum;
            cnt_d = len_i;
`ifdef FFIP_ACC_SAT_EN
            ovf_d = sat_ovf;
`endif
            if (len_i == '0) begin
              out_data_d  = sum;
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              state_d = ACC;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc_d = sum;
            cnt_d = cnt_q - LEN_SIZE'(1);
`ifdef FFIP_ACC_SAT_EN
            ovf_d = ovf_q | sat_ovf;
`endif
            if (cnt_q == LEN_SIZE'(1)) begin
              out_data_d  = sum;
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            state_d     = IDLE;
`ifdef FFIP_ACC_SAT_EN
            ovf_d       = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef FFIP_ACC_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef FFIP_ACC_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready_o  = (state_q != HOLD);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: doc/ffip_acc.md
Name: ffip_acc

Overview:
- Downstream consumer of the pre-add/multiply stage.
- Takes the stage's three signed product lanes per beat and forms the fast-inner-product term p0 - p1 - p2, which equals a0*b0 + a1*b1.
- Accumulates that term over a programmable number of beats and presents the dot-product result on a valid/ready output register.
- Sits between the add_mult array and the writeback/requantisation logic of the AI core.

Parameters:
PROD_SIZE, 18, width of each product lane ((IN_SIZE_1+1)*2 of the upstream stage)
ACC_SIZE, 32, accumulator and result width; must be >= PROD_SIZE+2
LEN_SIZE, 8, width of the group-length field

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; one clock; asynchronous, active-low
clear_i  input  1  synchronous abort/flush
len_i  input  LEN_SIZE  beats per group minus one; sampled on first beat of a group
in_valid_i  input  1  product beat valid
in_ready_o  output  1  block can accept a beat
prod_i  input  PROD_SIZE x [0:2]  signed products: [0] cross product, [1] and [2] correction products
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts result
out_data_o  output  ACC_SIZE  signed accumulated result
busy_o  output  1  group in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; acc=0; cnt=0; out_valid_o=0; out_data_o=0; in_ready_o=1.
- term: sext(prod_i[0]) - sext(prod_i[1]) - sext(prod_i[2]) at PROD_SIZE+2 bits, then sign-extended to ACC_SIZE. Two's-complement wrap on accumulate (see optional feature).
- Beat accepted when in_valid_i && in_ready_o.
- in_ready_o = (state != HOLD).
- State IDLE, on accepted beat:
  - acc <= term; cnt <= len_i; latch len.
  - If len_i==0, go to HOLD; else go to ACC.
- State ACC, on accepted beat:
  - acc <= acc + term; cnt <= cnt - 1.
  - When cnt==1, beat is last: load out_data_o with acc+term, go to HOLD.
  - No beat means no change. len_i is ignored in ACC.
- State HOLD:
  - out_valid_o=1; out_data_o stable.
  - On out_ready_i: out_valid_o <= 0, acc <= 0, go to IDLE.
- Latency: result valid the cycle after the last beat is accepted.
- Throughput: one group per (len+1) beats plus 1 handshake cycle minimum.
- clear_i:
  - Highest priority; same-cycle beat discarded.
  - Next cycle: state=IDLE, acc=0, cnt=0, out_valid_o=0.
  - out_data_o keeps its last value.
- Backpressure: out_valid_o, once raised, holds with out_data_o stable until out_ready_i.
- Max group length is 2^LEN_SIZE beats (len_i=255 gives 256).

Optional Feature:
- Macro FFIP_ACC_SAT_EN.
- Defined:
  - Accumulate saturates to the ACC_SIZE signed max/min, including the first beat.
  - Adds output port ovf_o (1 bit), a sticky flag per group. It is set on any saturation event, presented alongside out_data_o, and cleared on result handshake, clear_i or reset.
- Undefined: wrap-around arithmetic; no ovf_o port.

Decomposition:
- Package ffip_pkg holds:
  - state enum ffip_state_t {IDLE, ACC, HOLD};
  - localparam TERM_SIZE = PROD_SIZE+2 (as a function of parameters);
  - a saturating-add function used only when FFIP_ACC_SAT_EN is defined.
- One sub-module, ffip_term: combinational p0-p1-p2 with sign extension to ACC_SIZE. It is reusable by the parallel column variant.

Test Plan:
- len_i=0, prod={30,6,5} -> out_data_o=19 one cycle after beat; in_ready_o=0 until out_ready_i.
- len_i=3, four beats of prod={100,20,30}, in_valid_i gapped every other cycle -> out_data_o=200 after 4th accepted beat.
- len_i=1, beats {-50,10,5} and {0,-4,-4} -> out_data_o=-57; hold out_ready_i=0 for 5 cycles -> out_valid_o/out_data_o stable, in_valid_i ignored.
- clear_i mid-group (after 2 of 4 beats), then fresh group len_i=0 with {7,1,1} -> out_data_o=5, no residue from the aborted group.
- ACC_SIZE=20, repeated prod={131071,-131072,-131072} over 4 beats -> wraps without FFIP_ACC_SAT_EN; saturates to 524287 with ovf_o=1 when defined.
- rst_ni asserted in HOLD -> immediately out_valid_o=0, busy_o=0, in_ready_o=1, out_data_o=0.
